// File: rtl/nanov_alu_pkg.sv
// Shared encodings for the nanoV bit-serial ALU: op codes, FSM states, default width.
package nanov_alu_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SLT  = 3'd5;
  localparam logic [2:0] OP_SLTU = 3'd6;
  localparam logic [2:0] OP_MOV  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  // Ops that run the adder as a subtractor (inverted rs2, carry-in of 1).
  function automatic logic op_is_sub(input logic [2:0] o);
    return (o == OP_SUB) || (o == OP_SLT) || (o == OP_SLTU);
  endfunction

  function automatic logic op_is_cmp(input logic [2:0] o);
    return (o == OP_SLT) || (o == OP_SLTU);
  endfunction

endpackage

// File: rtl/nanov_serial_alu_adder.sv
// Serial full adder with carry flop; carry_in/carry_out expose the MSB carries for overflow.
module nanov_serial_adder (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic cin_load,
  input  logic cin_value,
  input  logic en,
  output logic sum,
  output logic carry_in,
  output logic carry_out
);

  logic r_carry;

  assign carry_in  = r_carry;
  assign sum       = a ^ b ^ r_carry;
  assign carry_out = (a & b) | (a & r_carry) | (b & r_carry);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_carry <= 1'b0;
    end else if (cin_load) begin
      r_carry <= cin_value;
    end else if (en) begin
      r_carry <= carry_out;
    end
  end

endmodule

// File: rtl/nanov_serial_alu.sv
// Bit-serial ALU between the nanoV register file read and write ports.
// Compare ops (SLT/SLTU) produce lt_out only when NANOV_ALU_CMP_EN is defined.
module nanov_serial_alu
  import nanov_alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [2:0]               op,
  input  logic                     rs1_bit,
  input  logic                     rs2_bit,
  output logic                     busy,
  output logic                     rd_bit,
  output logic                     rd_valid,
  output logic [$clog2(XLEN)-1:0]  rd_idx,
  output logic                     done,
  output logic                     lt_out
);

  localparam int CW = $clog2(XLEN);

  state_t         r_state;
  state_t         w_state_nx;
  logic [2:0]     r_op;
  logic [CW-1:0]  r_cnt;
  logic           r_rd_bit;
  logic           r_rd_valid;
  logic [CW-1:0]  r_rd_idx;
  logic           r_done;

  logic w_accept;
  logic w_last;
  logic w_b;
  logic w_sum;
  logic w_carry_in;
  logic w_carry_out;
  logic w_res;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_state == S_RUN) && (r_cnt == CW'(XLEN - 1));
  assign w_b      = rs2_bit ^ op_is_sub(r_op);

  nanov_serial_adder u_adder (
    .clk       (clk),
    .rst       (rst),
    .a         (rs1_bit),
    .b         (w_b),
    .cin_load  (w_accept),
    .cin_value (op_is_sub(op)),
    .en        (r_state == S_RUN),
    .sum       (w_sum),
    .carry_in  (w_carry_in),
    .carry_out (w_carry_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nx = S_RUN;
      S_RUN:   if (w_last) w_state_nx = S_FLUSH;
      S_FLUSH: w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_res = w_sum;
    case (r_op)
      OP_AND:  w_res = rs1_bit & rs2_bit;
      OP_OR:   w_res = rs1_bit | rs2_bit;
      OP_XOR:  w_res = rs1_bit ^ rs2_bit;
      OP_MOV:  w_res = rs1_bit;
      default: w_res = w_sum;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op       <= '0;
      r_cnt      <= '0;
      r_rd_bit   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_idx   <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done     <= w_last;
      r_rd_valid <= 1'b0;
      if (w_accept) begin
        r_op  <= op;
        r_cnt <= '0;
      end
      if (r_state == S_RUN) begin
        r_rd_bit   <= w_res;
        r_rd_idx   <= r_cnt;
        r_rd_valid <= !op_is_cmp(r_op);
        r_cnt      <= w_last ? '0 : r_cnt + CW'(1);
      end
    end
  end

`ifdef NANOV_ALU_CMP_EN
  logic r_lt;
  logic w_lt_calc;

  // Signed compare folds MSB overflow (carry into MSB xor carry out) into the sign bit.
  assign w_lt_calc = (r_op == OP_SLTU) ? ~w_carry_out
                                       : (w_sum ^ w_carry_in ^ w_carry_out);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lt <= 1'b0;
    end else if (w_accept && !op_is_cmp(op)) begin
      r_lt <= 1'b0;
    end else if (w_last && op_is_cmp(r_op)) begin
      r_lt <= w_lt_calc;
    end
  end

  assign lt_out = r_lt;
`else
  logic w_cmp_unused;
  assign w_cmp_unused = w_carry_in ^ w_carry_out;
  assign lt_out       = 1'b0;
`endif

  assign busy     = (r_state != S_IDLE);
  assign rd_bit   = r_rd_bit;
  assign rd_valid = r_rd_valid;
  assign rd_idx   = r_rd_idx;
  assign done     = r_done;

endmodule

// File: doc/nanov_serial_alu.md
Name: nanov_serial_alu

Overview:
Bit-serial ALU that sits between the nanoV register file's serial read ports and its serial write port. It consumes the rs1/rs2 bit streams LSB-first, one bit per clock, and produces the rd bit stream plus per-bit write qualifiers. Compare ops report a flag instead of writing rd. A start/busy/done handshake frames each XLEN-cycle operation.

Parameters:
XLEN, 32, operand width in bits; the bit counter is $clog2(XLEN) bits wide.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request a new op; sampled only in IDLE
op  input  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 MOV (rd=rs1)
rs1_bit  input  1  rs1 bit number cnt, valid while in RUN
rs2_bit  input  1  rs2 bit number cnt, valid while in RUN
busy  output  1  high in RUN and FLUSH
rd_bit  output  1  registered result bit
rd_valid  output  1  rd_bit is a result bit that must be written
rd_idx  output  5  bit index of rd_bit
done  output  1  one-cycle pulse when the op completes
lt_out  output  1  compare result, held until the next accepted start

Behaviour:
- Reset value of every output and all internal state is 0: state=IDLE, cnt=0, carry=0, op_q=0.
- States and transitions:
  - IDLE: on start=1, latch op into op_q, set cnt=0 and go to RUN. Carry is set to 1 for SUB, SLT and SLTU, and to 0 otherwise.
  - RUN: lasts XLEN cycles, with cnt running from 0 to XLEN-1. After the cycle with cnt=XLEN-1, go to FLUSH.
  - FLUSH: lasts one cycle, then return to IDLE.
- Timing, with start accepted at edge T0:
  - RUN occupies cycles T1..T32; the inputs carry bit cnt.
  - On each RUN edge, register the result into rd_bit, load rd_idx=cnt, and set rd_valid=1 except for SLT/SLTU.
  - rd stream visible T2..T33; done=1 during T33 (FLUSH), same cycle as last bit rd_idx=31.
  - Outside RUN, rd_valid is cleared on the next edge.
- Arithmetic:
  - Per bit, b' = rs2_bit XOR (op in {SUB, SLT, SLTU}); sum = a ^ b' ^ carry; carry_next = majority(a, b', carry).
  - ADD and SUB wrap modulo 2^XLEN; the final carry out is discarded.
  - AND, OR and XOR are bitwise; MOV passes rs1_bit.
- Compare ops:
  - Subtract as for SUB; rd_valid stays 0.
  - At cnt=XLEN-1, SLT gives lt = sum ^ overflow, where overflow = a_msb ^ b'_msb ^ ... computed as carry_in_msb ^ carry_out_msb. SLTU gives lt = ~carry_out_msb.
  - lt_out is registered at the edge that enters FLUSH.
  - For non-compare ops, lt_out is cleared at the edge that accepts start.
- Boundary conditions:
  - start while busy (RUN or FLUSH) is ignored; op changes after acceptance are ignored.
  - start in the same cycle as done is ignored; the earliest re-start is the first IDLE cycle.
  - rst asserted mid-op: immediate return to IDLE with all outputs 0; the partial result is abandoned with no done.
  - Back-to-back ops have one IDLE cycle minimum between them (19-cycle gap not required).

Optional Feature:
Macro NANOV_ALU_CMP_EN.
- Defined: SLT and SLTU behave as above.
- Undefined: ops 5 and 6 still run the full XLEN+1 cycle framing with rd_valid=0 and done pulsed; lt_out is tied 0 and the compare/overflow logic is not synthesised.

Decomposition:
- Shared package nanov_alu_pkg holds:
  - the op encoding constants (OP_ADD through OP_MOV);
  - the state encoding (S_IDLE, S_RUN, S_FLUSH);
  - the default XLEN.
- One natural sub-module, nanov_serial_adder: full adder plus carry flop, with inputs a, b, cin_load, cin_value and en, and outputs sum, carry_in and carry_out. The MSB overflow is derived from its carry_in and carry_out.

Test Plan:
- ADD 0xFFFFFFFF + 0x00000001 -> collected rd = 0x00000000; rd_valid high for 32 cycles, T2..T33; done on T33 with rd_idx=31.
- SUB 5 - 7 -> rd = 0xFFFFFFFE; XOR 0xA5A5A5A5 ^ 0x0F0F0F0F -> 0xAAAAAAAA; MOV 0x12345678 -> 0x12345678.
- SLT rs1=0xFFFFFFFF, rs2=0x00000001 -> lt_out=1, rd_valid never high. SLTU with the same operands -> lt_out=0. SLT 0x80000000 vs 0x7FFFFFFF -> 1 (overflow case).
- start pulsed at cnt=10 and again during FLUSH -> ignored; the first result is unchanged and exactly one done is seen.
- rst asserted at cnt=15 of an ADD -> busy, rd_valid, done and lt_out are all 0 immediately. A new ADD 3+4 afterwards -> 7.
- Build without NANOV_ALU_CMP_EN: SLT -1 vs 1 -> done after 33 cycles, lt_out=0, no rd writes.
